io_xbar_nib_fifo: RTL

Receive-side network input buffer (NIB) for one IO crossbar output port, sitting directly downstream of that port's credit counter. It stores flits sent by the upstream sender in a BUFFER_SIZE-entry circular FIFO and presents them to the local consumer. For every entry the consumer dequeues, it returns exactly one registered `yummy_out` pulse, so the upstream credit count stays exact.

---
 rtl/io_xbar_nib_fifo.sv | 113 +++++++++++
 1 files changed

// File: rtl/io_xbar_nib_fifo.sv
// io_xbar_nib_fifo
//   Receive-side network input buffer for one IO crossbar output port.
//   Flits from the upstream sender land in a BUFFER_SIZE-entry circular
//   FIFO. Each entry the consumer dequeues returns exactly one registered
//   yummy_out pulse, which keeps the upstream credit count exact.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   data_in      flit from upstream sender
//   valid_in     data_in valid (write request)
//   yummy_out    one-cycle credit-return pulse per dequeued entry
//   data_out     head-of-FIFO flit (combinational read of storage)
//   valid_out    FIFO non-empty
//   thanks_in    consumer dequeues the head this cycle
//   overflow_err sticky dropped-write flag
//
// Optional feature macro: IO_XBAR_NIB_OVERFLOW_CHK_EN
//   defined   -> overflow_err latches on the first write dropped at full
//   undefined -> overflow_err tied to 0 (drop behaviour identical)

module io_xbar_nib_fifo #(
    parameter int DATA_WIDTH  = 64,
    parameter int BUFFER_SIZE = 4,
    parameter int BUFFER_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  yummy_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  thanks_in,
    output logic                  overflow_err
);

    localparam logic [BUFFER_BITS-1:0] LAST_IDX = BUFFER_BITS'(BUFFER_SIZE - 1);
    localparam logic [BUFFER_BITS-1:0] FULL_CNT = BUFFER_BITS'(BUFFER_SIZE);

    logic [DATA_WIDTH-1:0]  fifo_mem [BUFFER_SIZE];
    logic [BUFFER_BITS-1:0] wr_ptr;
    logic [BUFFER_BITS-1:0] rd_ptr;
    logic [BUFFER_BITS-1:0] count_f;
    logic                   yummy_f;
    logic                   full;
    logic                   deq;
    logic                   enq;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [BUFFER_BITS-1:0] ptr_inc(input logic [BUFFER_BITS-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign full = (count_f == FULL_CNT);
    assign deq  = thanks_in && (count_f != '0);
    // A write at full is still accepted when the head leaves this cycle.
    assign enq  = valid_in && (!full || deq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_f <= '0;
            yummy_f <= 1'b0;
        end else begin
            if (enq) wr_ptr <= ptr_inc(wr_ptr);
            if (deq) rd_ptr <= ptr_inc(rd_ptr);
            case ({enq, deq})
                2'b10:   count_f <= count_f + 1'b1;
                2'b01:   count_f <= count_f - 1'b1;
                default: count_f <= count_f;
            endcase
            yummy_f <= deq;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            if (enq && (wr_ptr == BUFFER_BITS'(i))) fifo_mem[i] <= data_in;
        end
    end

    // At full with simultaneous enq/deq and wr_ptr == rd_ptr, this still
    // shows the old head; the slot is overwritten at the edge.
    always_comb begin
        data_out = fifo_mem[0];
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            if (rd_ptr == BUFFER_BITS'(i)) data_out = fifo_mem[i];
        end
    end

    assign valid_out = (count_f != '0);
    assign yummy_out = yummy_f;

`ifdef IO_XBAR_NIB_OVERFLOW_CHK_EN
    logic err_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_f <= 1'b0;
        end else if (valid_in && full && !deq) begin
            err_f <= 1'b1;
        end
    end

    assign overflow_err = err_f;
`else
    assign overflow_err = 1'b0;
`endif

endmodule
